// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz VGA timing constants and shared types for the display path.
// The pixel generator reuses the visible-window bounds for screen-relative math.
package vga_timing_pkg;

  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;

  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  localparam int H_VIS_START = H_SYNC + H_BP;
  localparam int H_VIS_END   = H_VIS_START + H_ACTIVE;
  localparam int V_VIS_START = V_SYNC + V_BP;
  localparam int V_VIS_END   = V_VIS_START + V_ACTIVE;

  localparam int CNT_W = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t h;
    cnt_t v;
  } vga_pos_t;

  // Inclusive window test; callers pass the last visible index, not one past it.
  function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/clk_enable_div.sv
// Clock-enable divider: one registered strobe every DIV clocks, aligned to the
// cycle in which the internal phase counter sits at DIV-1.
module clk_enable_div
  import vga_timing_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic en
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt;
  logic [W-1:0] div_cnt_nxt;

  generate
    if (DIV < 1) begin : g_bad_div
      $error("clk_enable_div: DIV must be at least 1");
    end
  endgenerate

  always_comb begin
    div_cnt_nxt = (div_cnt == LAST) ? '0 : div_cnt + W'(1);
  end

  // The strobe is registered from the next phase so it lines up with div_cnt == DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      en      <= 1'b0;
    end else begin
      div_cnt <= div_cnt_nxt;
      en      <= (div_cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, zero-latency sync and blanking decode,
// and per-frame / per-N-frame strobes for the game-state logic.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV         = 4,
  parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
  parameter int H_BP            = vga_timing_pkg::H_BP,
  parameter int H_ACTIVE        = vga_timing_pkg::H_ACTIVE,
  parameter int H_TOTAL         = vga_timing_pkg::H_TOTAL,
  parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
  parameter int V_BP            = vga_timing_pkg::V_BP,
  parameter int V_ACTIVE        = vga_timing_pkg::V_ACTIVE,
  parameter int V_TOTAL         = vga_timing_pkg::V_TOTAL,
  parameter int FRAMES_PER_TICK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_en,
  output logic       frame_tick,
  output logic       game_tick
);

  localparam cnt_t H_SYNC_C  = cnt_t'(H_SYNC);
  localparam cnt_t H_VIS_LO  = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t H_VIS_HI  = cnt_t'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_SYNC_C  = cnt_t'(V_SYNC);
  localparam cnt_t V_VIS_LO  = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t V_VIS_HI  = cnt_t'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
  localparam logic [7:0] FPT_LAST = 8'(FRAMES_PER_TICK - 1);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit the 10-bit counters");
    end
    if (H_SYNC + H_BP + H_ACTIVE > H_TOTAL) begin : g_bad_h
      $error("vga_timing_gen: horizontal sync+porch+active exceeds H_TOTAL");
    end
    if (V_SYNC + V_BP + V_ACTIVE > V_TOTAL) begin : g_bad_v
      $error("vga_timing_gen: vertical sync+porch+active exceeds V_TOTAL");
    end
    if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_active
      $error("vga_timing_gen: active area must be non-empty");
    end
    if (FRAMES_PER_TICK < 1 || FRAMES_PER_TICK > 255) begin : g_bad_fpt
      $error("vga_timing_gen: FRAMES_PER_TICK must be within 1..255");
    end
  endgenerate

  logic       pix_en_q;
  vga_pos_t   pos;
  logic       h_wrap;
  logic       v_wrap;
  logic       frame_wrap;
  logic [7:0] frame_cnt;
  logic       frame_tick_q;
  logic       game_tick_q;

  clk_enable_div #(
    .DIV (CLK_DIV)
  ) u_pix_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en_q)
  );

  assign h_wrap     = (pos.h == H_LAST);
  assign v_wrap     = (pos.v == V_LAST);
  assign frame_wrap = pix_en_q && h_wrap && v_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (pix_en_q) begin
      if (h_wrap) begin
        pos.h <= '0;
        pos.v <= v_wrap ? '0 : pos.v + cnt_t'(1);
      end else begin
        pos.h <= pos.h + cnt_t'(1);
      end
    end
  end

  // Both strobes are registered off the wrap edge so they appear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt    <= '0;
      frame_tick_q <= 1'b0;
      game_tick_q  <= 1'b0;
    end else begin
      frame_tick_q <= frame_wrap;
      game_tick_q  <= frame_wrap && (frame_cnt == FPT_LAST);
      if (frame_wrap) begin
        frame_cnt <= (frame_cnt == FPT_LAST) ? '0 : frame_cnt + 8'd1;
      end
    end
  end

  assign hCount     = pos.h;
  assign vCount     = pos.v;
  assign hSync      = (pos.h >= H_SYNC_C);
  assign vSync      = (pos.v >= V_SYNC_C);
  assign bright     = in_window(pos.h, H_VIS_LO, H_VIS_HI) && in_window(pos.v, V_VIS_LO, V_VIS_HI);
  assign pix_en     = pix_en_q;
  assign frame_tick = frame_tick_q;
  assign game_tick  = game_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster so several frames
// fit in a short run; expectations come from elapsed-cycle arithmetic.
module tb_vga_timing_gen;

  localparam int D     = 4;
  localparam int HS    = 3;
  localparam int HB    = 2;
  localparam int HA    = 8;
  localparam int HT    = 16;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam int VA    = 5;
  localparam int VT    = 12;
  localparam int FPT   = 3;
  localparam int FRAME = D * HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       pix_en;
  logic       frame_tick;
  logic       game_tick;

  int tests = 0;
  int fails = 0;
  int t = 0;

  int   bp_cnt, ft_cnt, last_ft_t, ival_min, ival_max, gt_mask, gt_first;
  int   hs_low, v_changes, v_change_h, prev_v;
  logic gt_orphan, tick_adjacent, prev_ft;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV         (D),
    .H_SYNC          (HS),
    .H_BP            (HB),
    .H_ACTIVE        (HA),
    .H_TOTAL         (HT),
    .V_SYNC          (VS),
    .V_BP            (VB),
    .V_ACTIVE        (VA),
    .V_TOTAL         (VT),
    .FRAMES_PER_TICK (FPT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hCount     (hCount),
    .vCount     (vCount),
    .hSync      (hSync),
    .vSync      (vSync),
    .bright     (bright),
    .pix_en     (pix_en),
    .frame_tick (frame_tick),
    .game_tick  (game_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: t = clk edges since reset release; everything follows from division.
  task automatic model_check();
    int   p, eh, ev;
    logic eft, egt;
    p   = t / D;
    eh  = p % HT;
    ev  = (p / HT) % VT;
    eft = (t > 0) && (t % FRAME == 0);
    egt = eft && ((t / FRAME) % FPT == 0);
    chk("hCount", hCount, eh);
    chk("vCount", vCount, ev);
    chk("hSync", hSync, (eh >= HS));
    chk("vSync", vSync, (ev >= VS));
    chk("bright", bright, (eh >= HS + HB) && (eh < HS + HB + HA) &&
                          (ev >= VS + VB) && (ev < VS + VB + VA));
    chk("pix_en", pix_en, (t % D == D - 1));
    chk("frame_tick", frame_tick, eft);
    chk("game_tick", game_tick, egt);
  endtask

  task automatic clear_tick_stats();
    ft_cnt = 0; last_ft_t = 0; ival_min = 1 << 30; ival_max = 0;
    gt_mask = 0; gt_first = -1; gt_orphan = 1'b0; tick_adjacent = 1'b0; prev_ft = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    t++;
    @(negedge clk);
    model_check();
    if (pix_en && bright) bp_cnt++;
    if (frame_tick) begin
      ft_cnt++;
      if (ft_cnt > 1) begin
        if (t - last_ft_t < ival_min) ival_min = t - last_ft_t;
        if (t - last_ft_t > ival_max) ival_max = t - last_ft_t;
      end
      last_ft_t = t;
      if (game_tick) gt_mask |= (1 << ft_cnt);
      if (game_tick && gt_first < 0) gt_first = t;
    end
    if (game_tick && !frame_tick) gt_orphan = 1'b1;
    if (frame_tick && prev_ft) tick_adjacent = 1'b1;
    prev_ft = frame_tick;
    if (t >= D * HT && t < 2 * D * HT && !hSync) hs_low++;
    if (t < 2 * D * HT && int'(vCount) != prev_v) begin
      v_changes++;
      v_change_h = hCount;
    end
    prev_v = vCount;
  endtask

  // Advance until the reference model sits on pixel (h,v).
  task automatic goto_pos(input int h, input int v);
    int n;
    n = 0;
    while (!(((t / D) % HT) == h && ((t / D / HT) % VT) == v) && n < 2 * FRAME) begin
      step();
      n++;
    end
    chk("goto_in_budget", (n < 2 * FRAME), 1'b1);
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_len, n, th, tv;
    bp_cnt = 0; hs_low = 0; v_changes = 0; v_change_h = -1; prev_v = 0;
    clear_tick_stats();

    rst_len = 10 + $urandom_range(0, 5);
    repeat (rst_len) @(negedge clk);
    t = 0;
    model_check();
    chk("rst_hSync", hSync, 1'b0);
    chk("rst_vSync", vSync, 1'b0);
    chk("rst_pix_en", pix_en, 1'b0);

    rst_n = 1'b1;
    n = 0;
    while (!pix_en && n < 4 * D) begin
      step();
      n++;
    end
    chk("first_pix_cycle", n + 1, D);

    while (t < 7 * FRAME + 2) step();
    chk("bright_pixels", bp_cnt, 7 * HA * VA);
    chk("frame_ticks", ft_cnt, 7);
    chk("ft_interval_min", ival_min, FRAME);
    chk("ft_interval_max", ival_max, FRAME);
    chk("game_tick_frames", gt_mask, (1 << 3) | (1 << 6));
    chk("game_without_frame", gt_orphan, 1'b0);
    chk("tick_adjacent", tick_adjacent, 1'b0);
    chk("hsync_low_cycles", hs_low, HS * D);
    chk("v_changes_line0", v_changes, 1);
    chk("v_change_at_wrap", v_change_h, 0);

    goto_pos(HS + HB, VS + VB);                chk("bright_first", bright, 1'b1);
    goto_pos(HS + HB + HA - 1, VS + VB + VA - 1); chk("bright_last", bright, 1'b1);
    goto_pos(HS + HB - 1, VS + VB);            chk("bright_left", bright, 1'b0);
    goto_pos(HS + HB + HA, VS + VB);           chk("bright_right", bright, 1'b0);
    goto_pos(HS + HB, VS + VB - 1);            chk("bright_top", bright, 1'b0);
    goto_pos(HS + HB, VS + VB + VA);           chk("bright_bottom", bright, 1'b0);

    for (int k = 0; k < 2; k++) begin
      th = $urandom_range(1, HT - 1);
      tv = $urandom_range(1, VT - 1);
      goto_pos(th, tv);
      n = $urandom_range(0, D - 1);
      repeat (n) step();
      rst_n = 1'b0;
      #1;
      chk("midrst_hCount", hCount, 0);
      chk("midrst_vCount", vCount, 0);
      chk("midrst_pix_en", pix_en, 1'b0);
      chk("midrst_hSync", hSync, 1'b0);
      chk("midrst_frame_tick", frame_tick, 1'b0);
      chk("midrst_game_tick", game_tick, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      t = 0;
      clear_tick_stats();
      while (t < FPT * FRAME + 2) step();
      chk("midrst_first_game_tick", gt_first, FPT * FRAME);
      chk("midrst_frame_ticks", ft_cnt, FPT);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
